oai22_sweep_tester: RTL



---
 rtl/oai22_sweep_pkg.sv | 34 +++
 rtl/oai22_sweep_seq.sv | 56 +++++
 rtl/oai22_sweep_tester.sv | 134 +++++++++++++
 3 files changed

// File: rtl/oai22_sweep_pkg.sv
// oai22_sweep_pkg: types, constants and helper functions shared by the OAI22
// sweep tester.
//   state_t      : sweep FSM states
//   VEC_W/NUM_VEC: CUT input vector width and number of vectors in a sweep
//   oai22_golden : ideal response ZN = ~((A1|A2)&(B1|B2)) for vec={A1,A2,B1,B2}
//   vec_of_index : maps a sweep index to the applied vector
// Optional macro OAI22_SWEEP_GRAY_EN selects Gray-code vector order
// (one CUT input toggles per step); binary order when undefined.
package oai22_sweep_pkg;

  localparam int VEC_W   = 4;
  localparam int NUM_VEC = 16;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  function automatic logic oai22_golden(input logic [VEC_W-1:0] vec);
    return ~((vec[3] | vec[2]) & (vec[1] | vec[0]));
  endfunction

  function automatic logic [VEC_W-1:0] vec_of_index(input logic [VEC_W-1:0] idx);
`ifdef OAI22_SWEEP_GRAY_EN
    return idx ^ (idx >> 1);
`else
    return idx;
`endif
  endfunction

endpackage

// File: rtl/oai22_sweep_seq.sv
// oai22_sweep_seq: vector index and pass counter for the OAI22 sweep tester.
//   CK, RN  : clock, asynchronous active-low reset
//   clear   : restart at index 0, pass 0
//   advance : step to the next vector (wraps 15->0 and bumps the pass count)
//   last    : current vector is index 15 of the final pass
//   vec_nxt : vector for the index that will be current after this edge,
//             so the top can register it into the stimulus flops in step
// Vector order follows vec_of_index (binary, or Gray with OAI22_SWEEP_GRAY_EN).
module oai22_sweep_seq
  import oai22_sweep_pkg::*;
#(
  parameter int PASSES = 1
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             clear,
  input  logic             advance,
  output logic             last,
  output logic [VEC_W-1:0] vec_nxt
);

  localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;

  logic [VEC_W-1:0]  idx;
  logic [VEC_W-1:0]  idx_nxt;
  logic [PASS_W-1:0] pass_idx;
  logic              idx_wrap;

  assign idx_wrap = (idx == VEC_W'(NUM_VEC - 1));
  assign last     = idx_wrap && (pass_idx == PASS_W'(PASSES - 1));

  // NUM_VEC is exactly 2^VEC_W, so the increment wraps 15->0 on its own.
  always_comb begin
    idx_nxt = idx;
    if (clear)
      idx_nxt = '0;
    else if (advance)
      idx_nxt = idx + 1'b1;
  end

  assign vec_nxt = vec_of_index(idx_nxt);

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      idx      <= '0;
      pass_idx <= '0;
    end else begin
      idx <= idx_nxt;
      if (clear)
        pass_idx <= '0;
      else if (advance && idx_wrap)
        pass_idx <= pass_idx + 1'b1;
    end
  end

endmodule

// File: rtl/oai22_sweep_tester.sv
// oai22_sweep_tester: on-chip stimulus/response harness for an OAI22 cell.
// Sweeps all 16 {A1,A2,B1,B2} vectors PASSES times, holding each for
// SETTLE_CYCLES+2 cycles, and compares the registered ZN against the ideal
// OAI22 response in the SAMPLE state.
//   CK, RN            : clock, asynchronous active-low reset
//   start             : run request, honoured only in IDLE or DONE
//   ZN                : CUT output (combinational from A1..B2)
//   A1, A2, B1, B2    : registered CUT stimulus
//   busy              : sweep in progress
//   done              : sticky completion flag, cleared by the next run
//   pass              : valid with done; 1 iff no mismatch was seen
//   err_cnt           : mismatch count, saturating at all-ones
//   first_fail_vec    : {A1,A2,B1,B2} of the first mismatch
//   first_fail_valid  : a mismatch was recorded in this run
// Optional macro OAI22_SWEEP_GRAY_EN selects Gray-code vector order.
module oai22_sweep_tester
  import oai22_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 5
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             start,
  input  logic             ZN,
  output logic             A1,
  output logic             A2,
  output logic             B1,
  output logic             B2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       first_fail_vec,
  output logic             first_fail_valid
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  state_t           state;
  logic [VEC_W-1:0] stim;
  logic [SET_W-1:0] settle_cnt;
  logic             zn_p1;
  logic             start_ok;
  logic             mismatch;
  logic [ERR_W-1:0] err_nxt;
  logic             last;
  logic [VEC_W-1:0] vec_nxt;

  assign {A1, A2, B1, B2} = stim;

  assign start_ok = start && ((state == IDLE) || (state == DONE));
  assign mismatch = (state == SAMPLE) && (zn_p1 != oai22_golden(stim));
  assign err_nxt  = mismatch ? sat_inc(err_cnt) : err_cnt;

  oai22_sweep_seq #(
    .PASSES (PASSES)
  ) u_seq (
    .CK      (CK),
    .RN      (RN),
    .clear   (start_ok),
    .advance ((state == SAMPLE) && !last),
    .last    (last),
    .vec_nxt (vec_nxt)
  );

  // ---- stage p1: CUT response capture (only consumed in SAMPLE) ----
  always_ff @(posedge CK) begin
    zn_p1 <= ZN;
  end

  // ---- control: sweep FSM, stimulus and result logging ----
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state            <= IDLE;
      stim             <= '0;
      settle_cnt       <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_cnt          <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state            <= APPLY;
            stim             <= vec_nxt;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_cnt          <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
          end
        end
        APPLY: begin
          settle_cnt <= SET_W'(SETTLE_CYCLES);
          state      <= (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
        end
        SETTLE: begin
          // Leaving when the count reaches 0 gives exactly SETTLE_CYCLES cycles here.
          settle_cnt <= settle_cnt - 1'b1;
          if (settle_cnt == SET_W'(1))
            state <= SAMPLE;
        end
        SAMPLE: begin
          err_cnt <= err_nxt;
          if (mismatch && !first_fail_valid) begin
            first_fail_vec   <= stim;
            first_fail_valid <= 1'b1;
          end
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nxt == '0);
          end else begin
            state <= APPLY;
            stim  <= vec_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
